uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit channel (DataIn / DataInValid / DataInReady) between up to four byte producers, such as the CPU memory-mapped TX path and a hardware trace/debug source. A granted producer keeps the channel for a whole burst, ended by a last-byte flag, so bursts never interleave on the serial line. The block sits between the producers and the UART's DataIn handshake and drives that handshake from a registered output stage.

## Interface
- NUM_REQ, 2: number of requesters, legal range 2..4.
- TIMEOUT, 1024: lock-release limit in cycles; used only with UART_ARB_TIMEOUT_EN; legal range 2..65535.

- Clock  in  1  system clock, rising edge.
- Reset  in  1  one clock; reset is asynchronous and active-low.
- ReqValid  in  NUM_REQ  per-requester byte valid.
- ReqData  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- ReqLast  in  NUM_REQ  marks the final byte of requester i's burst.
- ReqReady  out  NUM_REQ  byte accepted from requester i when ReqValid[i] && ReqReady[i].
- DataIn  out  8  byte to the UART.
- DataInValid  out  1  UART byte valid.
- DataInReady  in  1  UART can accept a byte.
- Grant  out  NUM_REQ  one-hot current lock owner; all zeros when idle.
- Busy  out  1  high while locked or while DataInValid is high.
- Timeout  out  1  one-cycle pulse when a lock is force-released.

## Operation
- Two states: IDLE and LOCKED. Reset values: IDLE, Grant=0, DataInValid=0, DataIn=0, Busy=0, Timeout=0, rr pointer `last`=NUM_REQ-1.
- IDLE:
  - ReqReady is all zeros.
  - If any ReqValid is high, the winner is the first requester with ReqValid high, scanning from (last+1) mod NUM_REQ upward with wrap.
  - On the clock edge: Grant=onehot(winner), last=winner, state goes to LOCKED.
- LOCKED:
  - Only the granted requester g sees ReqReady[g]=(!DataInValid || DataInReady). All other ReqReady bits are 0.
  - On an accept: DataIn<=ReqData[g] and DataInValid<=1.
  - If the accepted byte has ReqLast[g]=1: state goes to IDLE and Grant clears on the same edge.
- Output stage:
  - If DataInValid && DataInReady with no new accept, DataInValid<=0.
  - DataIn is held stable while DataInValid && !DataInReady.
- ReqValid high on a non-granted requester is ignored and left pending. No data is lost.
- ReqValid dropping mid-burst is legal. The lock is held (subject to the timeout below).
- Reset asserted mid-operation: all state clears immediately. An in-flight DataIn byte is dropped. The requester sees no acknowledgment for any byte that was not accepted.

## Timing
- Arbitration takes one cycle. ReqValid first sampled at edge k gives Grant high after k, earliest accept at edge k+1, and DataInValid high after k+1.
- Within a burst with DataInReady held high: one byte per cycle, no bubbles.
- Between bursts there is at least one IDLE cycle, during which the next winner is chosen.
- A byte accepted by the arbiter reaches DataIn with one cycle of latency.
- Grant, DataIn, DataInValid, Busy and Timeout are registered outputs. ReqReady is combinational from state, DataInValid and DataInReady.

## Configuration
- UART_ARB_TIMEOUT_EN defined:
  - A 16-bit idle counter runs in LOCKED. It increments on every cycle in which ReqValid[g]=0 and clears on any accept or on entry to LOCKED.
  - When the counter reaches TIMEOUT: state goes to IDLE, Grant clears, and Timeout pulses high for one cycle.
  - A pending DataIn byte is unaffected by the release.
  - An accept in the same cycle as the counter reaching TIMEOUT wins: no release, counter clears.
- UART_ARB_TIMEOUT_EN undefined: no counter is built, the lock is held indefinitely, and Timeout is tied to 0.

## Test plan
- Reset low then high; req0 sends 0x41,0x42(last) with DataInReady=1 -> Grant=01 one cycle after ReqValid; DataIn shows 0x41 then 0x42 on consecutive cycles; Grant=0 after the last byte; Busy falls one cycle later.
- req0 and req1 both valid with 2-byte bursts, repeated twice -> burst order req0, req1, req0, req1; never interleaved; one IDLE cycle between bursts.
- DataInReady held low for 5 cycles mid-burst -> DataIn and DataInValid stable for all 5 cycles, ReqReady[g]=0; transfer resumes with no byte lost or duplicated.
- Reset asserted while DataInValid=1 with a 3-byte burst half sent -> all outputs 0 immediately (asynchronously); after release, the first grant goes to req0.
- With UART_ARB_TIMEOUT_EN and TIMEOUT=8: req1 locks, sends 1 byte, then drops ReqValid -> Timeout pulses 8 cycles after the accept, Grant=0; pending req0 is granted next cycle.
- Accept on the exact cycle the counter hits TIMEOUT -> no Timeout pulse, lock retained.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin arbiter sharing one UART transmit channel between up to four
//   byte producers. A granted producer holds the channel for a whole burst
//   (closed by its last-byte flag), so bursts never interleave on the line.
//   The DataIn handshake towards the UART is driven from a registered stage.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   When defined, a lock whose owner has been silent for TIMEOUT cycles is
//   force-released and o_timeout pulses for one cycle. When undefined, no
//   counter exists and o_timeout is tied low.
//
// Parameters
//   NUM_REQ  number of requesters (2..4)
//   TIMEOUT  lock-release limit in cycles (2..65535), timeout build only
//
// Ports
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_req_valid      per-requester byte valid
//   i_req_data       per-requester byte, requester i at [8i+7:8i]
//   i_req_last       final byte of requester i's burst
//   o_req_ready      byte taken from requester i when valid && ready
//   o_data_in        byte to the UART
//   o_data_in_valid  UART byte valid
//   i_data_in_ready  UART can accept a byte
//   o_grant          one-hot lock owner, zero when idle
//   o_busy           high while locked or while o_data_in_valid is high
//   o_timeout        one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_data_in,
  output logic                 o_data_in_valid,
  input  logic                 i_data_in_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_busy,
  output logic                 o_timeout
);
  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic { S_IDLE = 1'b0, S_LOCKED = 1'b1 } state_t;

  state_t             r_state, w_state_next;
  logic [IW-1:0]      r_last, w_last_next;
  logic [IW-1:0]      r_owner, w_owner_next;
  logic [NUM_REQ-1:0] r_grant, w_grant_next;
  logic [7:0]         r_data, w_data_next;
  logic               r_valid, w_valid_next;
  logic               r_busy, w_busy_next;

  logic [IW-1:0]      w_win_idx;
  logic [IW-1:0]      w_scan;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic [7:0]         w_sel_data;
  logic               w_slot_free;
  logic               w_accept;
  logic               w_tmo_hit;

  // Owner's request lines, selected by the registered owner index.
  assign w_sel_valid = i_req_valid[r_owner];
  assign w_sel_last  = i_req_last[r_owner];
  assign w_sel_data  = i_req_data[{r_owner, 3'b000} +: 8];

  // The output register can take a byte when empty or draining this cycle.
  assign w_slot_free = !r_valid || i_data_in_ready;
  assign w_accept    = (r_state == S_LOCKED) && w_sel_valid && w_slot_free;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign o_req_ready[gi] = (r_state == S_LOCKED) && r_grant[gi] && w_slot_free;
    end
  endgenerate

  // Round-robin pick: scan from last+1 upward with wrap. Scanning from the far
  // end down lets the nearest valid requester overwrite earlier candidates.
  always_comb begin
    w_win_idx = '0;
    w_scan    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_scan = IW'((int'(r_last) + k) % NUM_REQ);
      if (i_req_valid[w_scan]) w_win_idx = w_scan;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] r_idle_cnt, w_idle_cnt_next;
  logic        r_timeout;

  // Release on the edge where the silent-cycle count would reach TIMEOUT.
  // An accept always carries a valid owner, so it can never coincide.
  assign w_tmo_hit = (r_state == S_LOCKED) && !w_accept && !w_sel_valid &&
                     (r_idle_cnt == 16'(TIMEOUT - 1));

  always_comb begin
    w_idle_cnt_next = r_idle_cnt;
    if (r_state == S_IDLE || w_accept || w_tmo_hit) begin
      w_idle_cnt_next = '0;
    end else if (!w_sel_valid) begin
      w_idle_cnt_next = r_idle_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_idle_cnt <= w_idle_cnt_next;
      r_timeout  <= w_tmo_hit;
    end
  end

  assign o_timeout = r_timeout;
`else
  logic [15:0] w_unused_timeout;
  assign w_unused_timeout = 16'(TIMEOUT);
  assign w_tmo_hit        = 1'b0;
  assign o_timeout        = 1'b0;
`endif

  // State register and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_last  <= IW'(NUM_REQ - 1);
      r_owner <= '0;
      r_grant <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_last  <= w_last_next;
      r_owner <= w_owner_next;
      r_grant <= w_grant_next;
      r_data  <= w_data_next;
      r_valid <= w_valid_next;
      r_busy  <= w_busy_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (|i_req_valid) w_state_next = S_LOCKED;
      end
      S_LOCKED: begin
        if ((w_accept && w_sel_last) || w_tmo_hit) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    w_last_next  = r_last;
    w_owner_next = r_owner;
    w_grant_next = r_grant;
    w_data_next  = r_data;
    w_valid_next = r_valid;

    if (r_state == S_IDLE && |i_req_valid) begin
      w_grant_next = NUM_REQ'(1) << w_win_idx;
      w_owner_next = w_win_idx;
      w_last_next  = w_win_idx;
    end else if (r_state == S_LOCKED && w_state_next == S_IDLE) begin
      w_grant_next = '0;
    end

    // A new accept refills the slot; otherwise a taken byte empties it.
    if (w_accept) begin
      w_data_next  = w_sel_data;
      w_valid_next = 1'b1;
    end else if (r_valid && i_data_in_ready) begin
      w_valid_next = 1'b0;
    end

    w_busy_next = (w_state_next == S_LOCKED) || w_valid_next;
  end

  assign o_grant         = r_grant;
  assign o_data_in       = r_data;
  assign o_data_in_valid = r_valid;
  assign o_busy          = r_busy;

endmodule
